video_timing_param: RTL and testbench

VIDEO_TIMING_PARAM -- requirements
Module: video_timing_param

---
 rtl/video_timing_param_if.sv | 31 +++
 rtl/video_timing_param.sv | 139 +++++++++++++
 tb/tb_video_timing_param.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_param_if.sv
// Pixel-domain bundle between the raster timing generator (slave) and the
// block that paces it and consumes its counters, blanks and syncs (master).
interface video_timing_param_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          clk_pix;
    logic [3:0]    hs_offset;
    logic [3:0]    vs_offset;
    logic [3:0]    hs_width;
    logic [3:0]    vs_width;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          hbl;
    logic          vbl;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic          line_start;
    logic          frame_start;

    modport master (
        output clk_pix, hs_offset, vs_offset, hs_width, vs_width,
        input  hc, vc, hbl, vbl, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        input  clk_pix, hs_offset, vs_offset, hs_width, vs_width,
        output hc, vc, hbl, vbl, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/video_timing_param.sv
// Parameterised raster timing generator: pixel/line counters, blanking flags and
// sync pulses whose start and length can be trimmed once per frame.
module video_timing_param #(
    parameter int HW        = 9,
    parameter int VW        = 9,
    parameter int H_TOTAL   = 384,
    parameter int HBL_START = 256,
    parameter int HBL_END   = 0,
    parameter int HS_START  = 300,
    parameter int HS_WIDTH  = 32,
    parameter int V_TOTAL   = 289,
    parameter int VBL_START = 241,
    parameter int VBL_END   = 17,
    parameter int VS_START  = 261,
    parameter int VS_WIDTH  = 8,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    video_timing_param_if.slave  vid
);
    localparam int W = ((HW > VW) ? HW : VW) + 1;

    typedef struct packed {
        logic [3:0] hs_offset;
        logic [3:0] hs_width;
        logic [3:0] vs_offset;
        logic [3:0] vs_width;
    } adj_t;

    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic          hbl_q, hbl_d, vbl_q, vbl_d;
    logic          hs_act_q, hs_act_d, vs_act_q, vs_act_d;
    logic          line_start_q, line_start_d, frame_start_q, frame_start_d;
    adj_t          sh_q, sh_d, adj_in;
    logic [W-1:0]  hs_start, hs_end, vs_start, vs_end;
    logic          h_last, v_last;

    function automatic logic [W-1:0] sext4(input logic [3:0] v);
        return {{(W-4){v[3]}}, v};
    endfunction

    // Trimmed sync window; the extra bit keeps negative starts recognisable before wrapping.
    function automatic logic [2*W-1:0] sync_window(input logic [W-1:0] base, width, total,
                                                   input logic [3:0]   off, adj);
        logic [W-1:0] s, l, e;
        s = base + sext4(off);
        if (s[W-1])          s = s + total;
        else if (s >= total) s = s - total;
        l = width + sext4(adj);
        if (l[W-1] || l == '0) l = W'(1);
        else if (l >= total)   l = total - W'(1);
        e = s + l;
        if (e >= total) e = e - total;
        return {s, e};
    endfunction

    assign adj_in = {vid.hs_offset, vid.hs_width, vid.vs_offset, vid.vs_width};
    assign {hs_start, hs_end} = sync_window(W'(HS_START), W'(HS_WIDTH), W'(H_TOTAL),
                                            sh_q.hs_offset, sh_q.hs_width);
    assign {vs_start, vs_end} = sync_window(W'(VS_START), W'(VS_WIDTH), W'(V_TOTAL),
                                            sh_q.vs_offset, sh_q.vs_width);
    assign h_last = (hc_q == HW'(H_TOTAL - 1));
    assign v_last = (vc_q == VW'(V_TOTAL - 1));

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        hc_d          = hc_q;
        vc_d          = vc_q;
        hbl_d         = hbl_q;
        vbl_d         = vbl_q;
        hs_act_d      = hs_act_q;
        vs_act_d      = vs_act_q;
        sh_d          = sh_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (vid.clk_pix) begin
            if (h_last) begin
                hc_d         = '0;
                line_start_d = 1'b1;
                if (v_last) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                    sh_d          = adj_in;
                end else begin
                    vc_d = vc_q + VW'(1);
                end
            end else begin
                hc_d = hc_q + HW'(1);
            end
            // Flags decode the pre-edge count; set is tested first so it wins a tie.
            if (hc_q == HW'(HBL_START))    hbl_d = 1'b1;
            else if (hc_q == HW'(HBL_END)) hbl_d = 1'b0;
            if (vc_q == VW'(VBL_START))    vbl_d = 1'b1;
            else if (vc_q == VW'(VBL_END)) vbl_d = 1'b0;
            if (W'(hc_q) == hs_start)      hs_act_d = 1'b1;
            else if (W'(hc_q) == hs_end)   hs_act_d = 1'b0;
            if (W'(vc_q) == vs_start)      vs_act_d = 1'b1;
            else if (W'(vc_q) == vs_end)   vs_act_d = 1'b0;
        end
    end

    // NOTE: synchronous reset inside the clocked block, non-blocking updates for all state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q          <= '0;
            vc_q          <= '0;
            hbl_q         <= 1'b0;
            vbl_q         <= 1'b0;
            hs_act_q      <= 1'b0;
            vs_act_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sh_q          <= adj_in;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hbl_q         <= hbl_d;
            vbl_q         <= vbl_d;
            hs_act_q      <= hs_act_d;
            vs_act_q      <= vs_act_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sh_q          <= sh_d;
        end
    end

    assign vid.hc          = hc_q;
    assign vid.vc          = vc_q;
    assign vid.hbl         = hbl_q;
    assign vid.vbl         = vbl_q;
    assign vid.hsync       = hs_act_q ~^ HS_POL;
    assign vid.vsync       = vs_act_q ~^ VS_POL;
    assign vid.de          = ~hbl_q & ~vbl_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_param.sv
// Directed bench for video_timing_param: five parameter sets share one clock and
// are exercised one after another through a common probe mux.
module tb_video_timing_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // True when pos lies in the circular window [start, start+len) of a ring of size total.
    function automatic bit in_win(input int pos, input int start, input int len, input int total);
        return ((pos - start + total) % total) < len;
    endfunction

    logic [4:0] rst = '1;
    video_timing_param_if vif_def ();
    video_timing_param_if vif_sm ();
    video_timing_param_if vif_cl ();
    video_timing_param_if vif_wr ();
    video_timing_param_if vif_po ();

    video_timing_param u_def (.clk(clk), .reset(rst[0]), .vid(vif_def.slave));
    video_timing_param #(
        .H_TOTAL(64), .HBL_START(48), .HBL_END(0), .HS_START(40), .HS_WIDTH(32),
        .V_TOTAL(10), .VBL_START(8), .VBL_END(1), .VS_START(6), .VS_WIDTH(2)
    ) u_sm (.clk(clk), .reset(rst[1]), .vid(vif_sm.slave));
    video_timing_param #(.HS_WIDTH(4)) u_cl (.clk(clk), .reset(rst[2]), .vid(vif_cl.slave));
    video_timing_param #(.HS_START(380), .HS_WIDTH(10)) u_wr (.clk(clk), .reset(rst[3]), .vid(vif_wr.slave));
    video_timing_param #(.HS_POL(1'b0), .VS_POL(1'b0)) u_po (.clk(clk), .reset(rst[4]), .vid(vif_po.slave));

    logic [24:0] pk [5];
    assign pk[0] = {vif_def.hc, vif_def.vc, vif_def.hbl, vif_def.vbl, vif_def.hsync, vif_def.vsync,
                    vif_def.de, vif_def.line_start, vif_def.frame_start};
    assign pk[1] = {vif_sm.hc, vif_sm.vc, vif_sm.hbl, vif_sm.vbl, vif_sm.hsync, vif_sm.vsync,
                    vif_sm.de, vif_sm.line_start, vif_sm.frame_start};
    assign pk[2] = {vif_cl.hc, vif_cl.vc, vif_cl.hbl, vif_cl.vbl, vif_cl.hsync, vif_cl.vsync,
                    vif_cl.de, vif_cl.line_start, vif_cl.frame_start};
    assign pk[3] = {vif_wr.hc, vif_wr.vc, vif_wr.hbl, vif_wr.vbl, vif_wr.hsync, vif_wr.vsync,
                    vif_wr.de, vif_wr.line_start, vif_wr.frame_start};
    assign pk[4] = {vif_po.hc, vif_po.vc, vif_po.hbl, vif_po.vbl, vif_po.hsync, vif_po.vsync,
                    vif_po.de, vif_po.line_start, vif_po.frame_start};

    int         sel = 0;
    logic       cur_pix = 1'b0;
    logic [8:0] p_hc, p_vc;
    logic       p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs;
    always_comb {p_hc, p_vc, p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs} = pk[sel];

    task automatic set_pix(input logic v);
        cur_pix = v;
        case (sel)
            0:       vif_def.clk_pix = v;
            1:       vif_sm.clk_pix  = v;
            2:       vif_cl.clk_pix  = v;
            3:       vif_wr.clk_pix  = v;
            default: vif_po.clk_pix  = v;
        endcase
    endtask

    // Scans whole lines of a 384-pixel DUT against the circular-window model.
    task automatic scan_lines(input string tag, input int n_lines, input bit half,
                              input int hs_s, input int hs_l, input logic pol);
        int en_cnt = 0, hs_hi = 0, hb_hi = 0, lines = 0, err = 0, guard = 0, pre;
        bit seen = 1'b0;
        logic last_pix, hb_exp;
        while (lines < n_lines && guard < 2000 * (n_lines + 1)) begin
            @(negedge clk);
            guard++;
            last_pix = cur_pix;
            if (last_pix) en_cnt++;
            if (p_ls) begin
                if (!last_pix) err++;
                if (seen) begin
                    check({tag, "_line_len"}, en_cnt, 384);
                    check({tag, "_hs_pixels"}, hs_hi, hs_l);
                    check({tag, "_hbl_pixels"}, hb_hi, 128);
                    lines++;
                end
                seen = 1'b1; en_cnt = 0; hs_hi = 0; hb_hi = 0;
            end
            if (seen) begin
                pre    = (int'(p_hc) + 383) % 384;
                hb_exp = in_win(pre, 256, 128, 384);
                if ((p_hs === pol) !== in_win(pre, hs_s, hs_l, 384)) err++;
                if (p_hbl !== hb_exp) err++;
                if (p_vbl !== 1'b0 || p_de !== ~hb_exp) err++;
                if (last_pix && p_hs === pol) hs_hi++;
                if (last_pix && p_hbl === 1'b1) hb_hi++;
            end
            set_pix(half ? ~cur_pix : 1'b1);
        end
        check({tag, "_lines"}, lines, n_lines);
        check({tag, "_model"}, err, 0);
    endtask

    initial begin
        int guard, chg, fs_n, cyc, ln, hs_hi, err_b, err_c, e, ph, pv;
        bit applied;
        logic [24:0] snap;
        string tag;
        logic hb_x, vb_x;

        vif_def.clk_pix = 0; vif_sm.clk_pix = 0; vif_cl.clk_pix = 0; vif_wr.clk_pix = 0; vif_po.clk_pix = 0;
        {vif_def.hs_offset, vif_def.hs_width, vif_def.vs_offset, vif_def.vs_width} = '0;
        {vif_sm.hs_offset, vif_sm.hs_width, vif_sm.vs_offset, vif_sm.vs_width}     = '0;
        {vif_cl.hs_offset, vif_cl.vs_offset, vif_cl.vs_width} = '0;
        vif_cl.hs_width = 4'b1000;
        {vif_wr.hs_offset, vif_wr.hs_width, vif_wr.vs_offset, vif_wr.vs_width}     = '0;
        {vif_po.hs_offset, vif_po.hs_width, vif_po.vs_offset, vif_po.vs_width}     = '0;

        // Default timing: reset held with clk_pix high, then half-rate pixel enable.
        sel = 0;
        set_pix(1'b1);
        repeat (3) @(negedge clk);
        check("def_reset", {p_hc, p_vc, p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs}, {18'd0, 4'b0000, 3'b100});
        rst[0] = 1'b0;
        @(negedge clk);
        check("def_first_hc", p_hc, 1);
        set_pix(1'b0);
        scan_lines("def", 2, 1'b1, 300, 32, 1'b1);

        // Freeze in the middle of hsync for 50 clocks.
        set_pix(1'b1);
        guard = 0;
        do begin @(negedge clk); guard++; end while (p_hc != 9'd310 && guard < 1000);
        check("def_reach_310", p_hc, 310);
        set_pix(1'b0);
        snap = {p_hc, p_vc, p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs};
        chg = 0;
        repeat (50) begin
            @(negedge clk);
            if ({p_hc, p_vc, p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs} !== snap) chg++;
        end
        check("def_freeze", chg, 0);
        check("def_freeze_hs", p_hs, 1);
        set_pix(1'b1);
        @(negedge clk);
        check("def_resume", p_hc, 311);

        // Small raster: frame lengths, vertical flags and once-per-frame sync trimming.
        sel = 1;
        set_pix(1'b1);
        repeat (2) @(negedge clk);
        rst[1] = 1'b0;
        fs_n = 0; cyc = 0; ln = 0; hs_hi = 0; err_b = 0; err_c = 0; guard = 0; applied = 1'b0;
        while (fs_n < 3 && guard < 2500) begin
            @(negedge clk);
            guard++;
            if (p_fs) begin
                if (fs_n > 0) begin
                    check("sm_frame_pixels", cyc, 640);
                    check("sm_frame_lines", ln, 10);
                end
                fs_n++; cyc = 0; ln = 0;
            end
            cyc++;
            if (p_ls) begin
                ln++;
                if (p_vc == 9'd6 && fs_n >= 1) begin
                    tag = (fs_n == 1) ? "sm_hs_len_cur" : "sm_hs_len_next";
                    check(tag, hs_hi, (fs_n == 1) ? 32 : 39);
                end
                hs_hi = 0;
            end
            if (p_hs === 1'b1) hs_hi++;
            if (fs_n >= 1) begin
                ph   = (int'(p_hc) + 63) % 64;
                pv   = (ph == 63) ? (int'(p_vc) + 9) % 10 : int'(p_vc);
                hb_x = in_win(ph, 48, 16, 64);
                vb_x = in_win(pv, 8, 3, 10);
                e = 0;
                if (p_hs !== in_win(ph, (fs_n == 1) ? 40 : 32, (fs_n == 1) ? 32 : 39, 64)) e++;
                if (p_vs !== in_win(pv, 6, 2, 10)) e++;
                if (p_hbl !== hb_x || p_vbl !== vb_x || p_de !== ~(hb_x | vb_x)) e++;
                if (p_ls !== (p_hc == 9'd0) || p_fs !== (p_hc == 9'd0 && p_vc == 9'd0)) e++;
                if (fs_n == 1) err_b += e; else err_c += e;
            end
            if (fs_n == 1 && !applied && p_vc == 9'd4) begin
                vif_sm.hs_offset = 4'b1000;
                vif_sm.hs_width  = 4'b0111;
                applied = 1'b1;
            end
        end
        check("sm_frames", fs_n, 3);
        check("sm_model_cur", err_b, 0);
        check("sm_model_next", err_c, 0);

        // Width trimmed below one pixel clamps to a single pixel.
        sel = 2;
        set_pix(1'b1);
        @(negedge clk);
        rst[2] = 1'b0;
        scan_lines("clamp", 2, 1'b0, 300, 1, 1'b1);

        // Sync window straddling the line wrap.
        sel = 3;
        set_pix(1'b1);
        @(negedge clk);
        rst[3] = 1'b0;
        scan_lines("wrap", 2, 1'b0, 380, 10, 1'b1);

        // Active-low syncs and reset asserted deep inside a frame.
        sel = 4;
        set_pix(1'b1);
        @(negedge clk);
        check("pol_idle", {p_hs, p_vs}, 2'b11);
        rst[4] = 1'b0;
        scan_lines("pol", 1, 1'b0, 300, 32, 1'b0);
        guard = 0;
        do begin @(negedge clk); guard++; end while (!(p_hc == 9'd200 && p_vc == 9'd100) && guard < 40000);
        check("pol_reach", {p_vc, p_hc}, {9'd100, 9'd200});
        rst[4] = 1'b1;
        @(negedge clk);
        check("pol_reset", {p_hc, p_vc, p_hbl, p_vbl, p_hs, p_vs, p_de, p_ls, p_fs}, {18'd0, 4'b0011, 3'b100});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
